// File: rtl/alu_exec_pkg.sv
// Shared definitions for the EX-stage ALU execution unit: ALUCtrl codes
// (common with the ALU control decoder), FSM state encoding and latencies.
// Build option: ALU_EXEC_FAST_MUL_EN selects a single-cycle multiply.
package alu_exec_pkg;

   // ALUCtrl codes; every other value is treated as illegal
   localparam logic [3:0] OP_ADD     = 4'b0001;
   localparam logic [3:0] OP_SUB     = 4'b0010;
   localparam logic [3:0] OP_AND     = 4'b0011;
   localparam logic [3:0] OP_OR      = 4'b0100;
   localparam logic [3:0] OP_MUL     = 4'b0110;
   localparam logic [3:0] OP_RELU    = 4'b0111;
   localparam logic [3:0] OP_MAXPOOL = 4'b1000;
   localparam logic [3:0] OP_FC      = 4'b1001;
   localparam logic [3:0] OP_CONV    = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DOT  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Accept-to-done latency in cycles
   localparam int LAT_SINGLE = 1;

   function automatic int lat_mul(input int xlen);
`ifdef ALU_EXEC_FAST_MUL_EN
      return LAT_SINGLE;
`else
      return xlen + 1;
`endif
   endfunction

   // One byte lane per cycle plus the result cycle
   function automatic int lat_dot(input int xlen);
      return xlen / 8 + 1;
   endfunction

endpackage

// File: rtl/alu_exec_unit_shift_add_mul.sv
// Iterative shift-add multiplier, low XLEN bits of a*b, one multiplier bit per cycle.
// Latency: start cycle loads operands; done is high combinationally in the XLEN-th busy cycle,
// with product carrying the final sum in that same cycle. No backpressure: caller starts only when idle.
// Ports: clk, rst (async active-high), start, a, b, done, product.
module shift_add_mul #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CW = $clog2(XLEN);

   logic            busy;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] sum_next;

   assign sum_next = sum + (mplier[0] ? mcand : '0);

   // Final partial sum is exposed in the last cycle so the caller can
   // register the result on the same edge as the last iteration.
   assign done    = busy && (cnt == CW'(XLEN - 1));
   assign product = sum_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         sum    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         mcand  <= a;
         mplier <= b;
         sum    <= '0;
      end else if (busy) begin
         sum    <= sum_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU execution unit: integer ops, multiply and CNN ops (ReLU, MaxPool, FC, Conv2d).
// Latency: 1 for simple ops/illegal, XLEN+1 for MUL/FC (1 with ALU_EXEC_FAST_MUL_EN), XLEN/8+1 for Conv2d.
// Backpressure: ready_o drops while a multi-cycle op runs; requests are held upstream until accepted.
// Ports: clk_i, rst_i (async active-high), valid_i/ready_o handshake, ALUCtrl_i, data1_i, data2_i,
//        acc_clr_i (accumulator clear), done_o strobe with data_o, zero_o, illegal_o.
// Build option: ALU_EXEC_FAST_MUL_EN -> single-cycle multiply, no MULT state, no shift_add_mul.
// XLEN must be a multiple of 8.
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [3:0]      ALUCtrl_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic            acc_clr_i,
   output logic            ready_o,
   output logic            done_o,
   output logic [XLEN-1:0] data_o,
   output logic            zero_o,
   output logic            illegal_o
);

   localparam int NLANES = lat_dot(XLEN) - LAT_SINGLE;
   localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;

   state_t          state, state_next;
   logic [XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0] opa, opa_next;
   logic [XLEN-1:0] opb, opb_next;
   logic [LW-1:0]   lane, lane_next;
   logic            res_load;
   logic [XLEN-1:0] res_val;
   logic            res_ill;
   logic            accept;
   logic [XLEN-1:0] acc_base;
   logic signed [15:0]     lane_prod;
   logic [XLEN-1:0] lane_ext;

   // Signed max over byte lanes, sign-extended
   function automatic logic [XLEN-1:0] maxpool(input logic [XLEN-1:0] v);
      logic signed [7:0] m;
      logic signed [7:0] b;
      m = v[7:0];
      for (int k = 1; k < NLANES; k++) begin
         b = v[8*k +: 8];
         if (b > m) m = b;
      end
      return XLEN'(m);
   endfunction

   assign ready_o = (state == ST_IDLE) || (state == ST_FIN);
   assign accept  = valid_i && ready_o;

   // A clear coinciding with an FC/Conv2d accept makes that op start from 0
   assign acc_base = acc_clr_i ? '0 : acc;

   // Conv2d consumes the low byte of the shifting operand copies each cycle
   assign lane_prod = $signed(opa[7:0]) * $signed(opb[7:0]);
   assign lane_ext  = XLEN'(lane_prod);

`ifndef ALU_EXEC_FAST_MUL_EN
   logic [3:0]      op, op_next;
   logic            mul_start;
   logic            mul_done;
   logic [XLEN-1:0] mul_prod;

   shift_add_mul #(.XLEN(XLEN)) u_mul (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (mul_start),
      .a       (data1_i),
      .b       (data2_i),
      .done    (mul_done),
      .product (mul_prod)
   );
`else
   logic [XLEN-1:0] fast_prod;
   assign fast_prod = data1_i * data2_i;
`endif

   always_comb begin
      state_next = state;
      acc_next   = acc;
      opa_next   = opa;
      opb_next   = opb;
      lane_next  = lane;
      res_load   = 1'b0;
      res_val    = '0;
      res_ill    = 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
      op_next    = op;
      mul_start  = 1'b0;
`endif
      case (state)
         ST_IDLE, ST_FIN: begin
            state_next = ST_IDLE;
            if (acc_clr_i) acc_next = '0;
            if (accept) begin
`ifndef ALU_EXEC_FAST_MUL_EN
               op_next = ALUCtrl_i;
`endif
               case (ALUCtrl_i)
                  OP_ADD:     begin res_load = 1'b1; res_val = data1_i + data2_i; end
                  OP_SUB:     begin res_load = 1'b1; res_val = data1_i - data2_i; end
                  OP_AND:     begin res_load = 1'b1; res_val = data1_i & data2_i; end
                  OP_OR:      begin res_load = 1'b1; res_val = data1_i | data2_i; end
                  OP_RELU:    begin res_load = 1'b1; res_val = data1_i[XLEN-1] ? '0 : data1_i; end
                  OP_MAXPOOL: begin res_load = 1'b1; res_val = maxpool(data1_i); end
`ifdef ALU_EXEC_FAST_MUL_EN
                  OP_MUL: begin
                     res_load = 1'b1;
                     res_val  = fast_prod;
                  end
                  OP_FC: begin
                     res_load = 1'b1;
                     res_val  = acc_base + fast_prod;
                     acc_next = res_val;
                  end
`else
                  OP_MUL, OP_FC: begin
                     mul_start  = 1'b1;
                     state_next = ST_MULT;
                  end
`endif
                  OP_CONV: begin
                     opa_next   = data1_i;
                     opb_next   = data2_i;
                     lane_next  = '0;
                     state_next = ST_DOT;
                  end
                  default: begin
                     // Unrecognised code: zero result, accumulator untouched
                     res_load = 1'b1;
                     res_ill  = 1'b1;
                  end
               endcase
            end
         end
`ifndef ALU_EXEC_FAST_MUL_EN
         ST_MULT: begin
            if (mul_done) begin
               res_load   = 1'b1;
               state_next = ST_FIN;
               if (op == OP_FC) begin
                  res_val  = acc + mul_prod;
                  acc_next = res_val;
               end else begin
                  res_val = mul_prod;
               end
            end
         end
`endif
         ST_DOT: begin
            // Accumulate directly into acc; a clear here is ignored for the running op
            acc_next  = acc + lane_ext;
            opa_next  = opa >> 8;
            opb_next  = opb >> 8;
            lane_next = lane + LW'(1);
            if (lane == LW'(NLANES - 1)) begin
               res_load   = 1'b1;
               res_val    = acc_next;
               state_next = ST_FIN;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc       <= '0;
         opa       <= '0;
         opb       <= '0;
         lane      <= '0;
         done_o    <= 1'b0;
         data_o    <= '0;
         zero_o    <= 1'b1;
         illegal_o <= 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
         op        <= '0;
`endif
      end else begin
         acc    <= acc_next;
         opa    <= opa_next;
         opb    <= opb_next;
         lane   <= lane_next;
         done_o <= res_load;
`ifndef ALU_EXEC_FAST_MUL_EN
         op     <= op_next;
`endif
         // Result flags move only together with a done strobe
         if (res_load) begin
            data_o    <= res_val;
            zero_o    <= (res_val == '0);
            illegal_o <= res_ill;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32): directed vectors plus randomized
// operations compared with a behavioural model of results, latency and accumulator.
// Honours ALU_EXEC_FAST_MUL_EN for the expected multiply latency.
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

`ifdef ALU_EXEC_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int CONV_LAT = 5;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [3:0]  ALUCtrl_i;
   logic [31:0] data1_i, data2_i;
   logic        acc_clr_i;
   logic        ready_o, done_o, zero_o, illegal_o;
   logic [31:0] data_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model_acc = '0;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .acc_clr_i (acc_clr_i),
      .ready_o   (ready_o),
      .done_o    (done_o),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .illegal_o (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural reference: result, illegal flag, latency, accumulator update
   function automatic void model(input logic [3:0] op, input logic [31:0] a, b, input bit clr,
                                 inout logic [31:0] acc, output logic [31:0] res,
                                 output bit ill, output int lat);
      int  s;
      byte x, y, m;
      res = '0; ill = 1'b0; lat = 1;
      if (clr) acc = '0;
      case (op)
         4'b0001: res = a + b;
         4'b0010: res = a - b;
         4'b0011: res = a & b;
         4'b0100: res = a | b;
         4'b0110: begin res = a * b; lat = MUL_LAT; end
         4'b0111: res = (signed'(a) >= 0) ? a : 32'd0;
         4'b1000: begin
            m = a[7:0];
            for (int k = 1; k < 4; k++) begin
               x = a[8*k +: 8];
               if (x > m) m = x;
            end
            res = 32'(int'(m));
         end
         4'b1001: begin acc = acc + a * b; res = acc; lat = MUL_LAT; end
         4'b1010: begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
               x = a[8*k +: 8];
               y = b[8*k +: 8];
               s = s + x * y;
            end
            acc = acc + 32'(s);
            res = acc;
            lat = CONV_LAT;
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Drive one request at a negedge with ready_o=1 and wait (bounded) for done_o.
   // With noise set, valid_i is raised with junk while ready_o is low.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input bit clr, input bit noise,
                        output logic [31:0] res, output bit ill, output bit zero,
                        output int lat, output int rdy_low);
      valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b; acc_clr_i = clr;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0; acc_clr_i = 1'b0; lat = 1; rdy_low = 0;
      while (done_o !== 1'b1 && lat < 100) begin
         if (ready_o !== 1'b1) rdy_low++;
         valid_i   = noise && (ready_o === 1'b0);
         ALUCtrl_i = OP_ADD;
         data1_i   = $urandom;
         data2_i   = $urandom;
         @(negedge clk_i);
         lat++;
      end
      valid_i = 1'b0;
      res = data_o; ill = illegal_o; zero = zero_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 1'b0; ALUCtrl_i = '0; data1_i = '0; data2_i = '0; acc_clr_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_o); end
      n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", data_o); end
      n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b want=1", zero_o); end
      n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b want=0", illegal_o); end
      rst_i = 1'b0;
      model_acc = '0;
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  pool [6];
      logic [3:0]  ops [$];
      logic [31:0] av [$], bv [$], ex [$];
      logic [31:0] r;
      bit          il;
      int          lt;
      pool = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RELU, OP_MAXPOOL};
      ops = '{OP_ADD, OP_SUB, OP_AND};
      av  = '{32'd5, 32'd3, 32'h0000F0F0};
      bv  = '{32'd7, 32'd5, 32'h00000FF0};
      ex  = '{32'd12, 32'hFFFFFFFE, 32'h000000F0};
      for (int i = 0; i < 20; i++) begin
         ops.push_back(pool[$urandom_range(0, 5)]);
         av.push_back($urandom);
         bv.push_back($urandom);
         model(ops[i+3], av[i+3], bv[i+3], 1'b0, model_acc, r, il, lt);
         ex.push_back(r);
      end
      for (int i = 0; i <= ops.size(); i++) begin
         if (i > 0) begin
            n_checks++;
            if (done_o !== 1'b1 || data_o !== ex[i-1]) begin
               n_fail++; $display("FAIL b2b_result[%0d] got done=%b data=%h want done=1 data=%h", i-1, done_o, data_o, ex[i-1]);
            end
         end
         n_checks++;
         if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, ready_o); end
         if (i < ops.size()) begin
            valid_i = 1'b1; ALUCtrl_i = ops[i]; data1_i = av[i]; data2_i = bv[i];
            @(posedge clk_i);
            @(negedge clk_i);
         end
      end
      valid_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_mul();
      logic [31:0] r, er;
      bit il, z, eil;
      int lt, rl, elt;
      issue(OP_MUL, 32'h10000, 32'h10000, 1'b0, 1'b1, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd0 || z !== 1'b1) begin n_fail++; $display("FAIL mul_wrap got data=%h zero=%b want data=0 zero=1", r, z); end
      n_checks++; if (lt !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency got=%0d want=%0d", lt, MUL_LAT); end
      n_checks++; if (rl !== MUL_LAT - 1) begin n_fail++; $display("FAIL mul_ready_low got=%0d want=%0d", rl, MUL_LAT - 1); end
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mul_ready_at_done got=%b want=1", ready_o); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom;
         model(OP_MUL, a, b, 1'b0, model_acc, er, eil, elt);
         issue(OP_MUL, a, b, 1'b0, 1'b1, r, il, z, lt, rl);
         n_checks++;
         if (r !== er || lt !== elt || il !== 1'b0) begin
            n_fail++; $display("FAIL mul_rand[%0d] got data=%h lat=%0d ill=%b want data=%h lat=%0d ill=0", i, r, lt, il, er, elt);
         end
      end
   endtask

   task automatic test_cnn_ops();
      logic [31:0] r;
      bit il, z;
      int lt, rl;
      issue(OP_RELU, 32'h80000001, 32'd0, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || lt !== 1) begin n_fail++; $display("FAIL relu_neg got data=%h zero=%b lat=%0d want 0/1/1", r, z, lt); end
      issue(OP_RELU, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'h7FFFFFFF || z !== 1'b0) begin n_fail++; $display("FAIL relu_pos got data=%h zero=%b want 7fffffff/0", r, z); end
      issue(OP_MAXPOOL, 32'h7F80FE01, 32'd0, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'h0000007F) begin n_fail++; $display("FAIL maxpool got=%h want=0000007f", r); end
      issue(OP_MAXPOOL, 32'h80FF81FE, 32'd0, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL maxpool_neg got=%h want=ffffffff", r); end
      issue(4'b0101, 32'h1234, 32'h5678, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd0 || il !== 1'b1 || lt !== 1) begin n_fail++; $display("FAIL illegal got data=%h ill=%b lat=%0d want 0/1/1", r, il, lt); end
   endtask

   task automatic test_accumulate();
      logic [31:0] r, er;
      bit il, z, eil;
      int lt, rl, elt;
      model(OP_FC, 32'd3, 32'd4, 1'b1, model_acc, er, eil, elt);
      issue(OP_FC, 32'd3, 32'd4, 1'b1, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd12 || lt !== MUL_LAT) begin n_fail++; $display("FAIL fc_first got data=%0d lat=%0d want 12/%0d", r, lt, MUL_LAT); end
      model(OP_FC, 32'd2, 32'd5, 1'b0, model_acc, er, eil, elt);
      issue(OP_FC, 32'd2, 32'd5, 1'b0, 1'b1, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd22) begin n_fail++; $display("FAIL fc_second got=%0d want=22", r); end
      model(OP_CONV, 32'h01020304, 32'hFFFFFFFF, 1'b0, model_acc, er, eil, elt);
      issue(OP_CONV, 32'h01020304, 32'hFFFFFFFF, 1'b0, 1'b1, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd12 || lt !== CONV_LAT) begin n_fail++; $display("FAIL conv got data=%0d lat=%0d want 12/%0d", r, lt, CONV_LAT); end
      n_checks++; if (rl !== CONV_LAT - 1) begin n_fail++; $display("FAIL conv_ready_low got=%0d want=%0d", rl, CONV_LAT - 1); end
   endtask

   task automatic test_random_mix();
      logic [31:0] r, er, a, b;
      logic [3:0] op;
      bit il, z, eil, clr;
      int lt, rl, elt;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom;
         clr = ($urandom_range(0, 3) == 0);
         model(op, a, b, clr, model_acc, er, eil, elt);
         issue(op, a, b, clr, 1'($urandom_range(0, 1)), r, il, z, lt, rl);
         n_checks++;
         if (r !== er || il !== eil || z !== (er == 32'd0) || lt !== elt) begin
            n_fail++;
            $display("FAIL mix[%0d] op=%b got data=%h ill=%b zero=%b lat=%0d want data=%h ill=%b zero=%b lat=%0d",
                     i, op, r, il, z, lt, er, eil, (er == 32'd0), elt);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] r;
      bit il, z;
      int lt, rl, stray;
      stray = 0;
      // Make sure the accumulator is non-zero before the reset
      issue(OP_FC, 32'd7, 32'd9, 1'b1, 1'b0, r, il, z, lt, rl);
`ifdef ALU_EXEC_FAST_MUL_EN
      valid_i = 1'b1; ALUCtrl_i = OP_CONV;
`else
      valid_i = 1'b1; ALUCtrl_i = OP_MUL;
`endif
      data1_i = 32'h01234567; data2_i = 32'h0000FFFF;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (done_o !== 1'b0) stray++;
      end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_done got=%0d strobes want=0", stray); end
      n_checks++; if (ready_o !== 1'b1 || data_o !== 32'd0) begin n_fail++; $display("FAIL rst_mid_state got ready=%b data=%h want 1/0", ready_o, data_o); end
      model_acc = '0;
      issue(OP_FC, 32'd1, 32'd1, 1'b0, 1'b0, r, il, z, lt, rl);
      n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL rst_mid_acc got=%0d want=1", r); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mul();
      test_cnn_ops();
      test_accumulate();
      test_random_mix();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder in the EX stage. Accepts one operation per handshake and runs single-cycle integer ops plus multi-cycle multiply and CNN ops (ReLU, MaxPool, FC, Conv2d). Keeps an internal accumulator for FC/Conv2d and holds the pipeline through `ready_o` while a multi-cycle op runs. Results return on a one-cycle `done_o` pulse.

## Interface
- `XLEN`, 32, operand/result width; must be a multiple of 8.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  request valid.
- `ALUCtrl_i`  in  4  operation code, sampled on accept.
- `data1_i`  in  XLEN  operand 1, sampled on accept.
- `data2_i`  in  XLEN  operand 2, sampled on accept.
- `acc_clr_i`  in  1  clear accumulator.
- `ready_o`  out  1  unit can accept.
- `done_o`  out  1  one-cycle result strobe.
- `data_o`  out  XLEN  result, valid when `done_o`, held until the next `done_o`.
- `zero_o`  out  1  `data_o == 0`, updated with `data_o`.
- `illegal_o`  out  1  with `done_o`: code was unrecognised.

## Operation
- Accept when `valid_i && ready_o`. Operands and code are latched. `valid_i` while `ready_o=0` is ignored; upstream holds the request.
- Codes:
  - 0001 ADD: `data1 + data2`, mod 2^XLEN.
  - 0010 SUB: `data1 - data2`, mod 2^XLEN.
  - 0011 AND.
  - 0100 OR.
  - 0110 MUL: low XLEN bits of the product.
  - 0111 ReLU: `data1` if signed `data1 >= 0`, else 0.
  - 1000 MaxPool: signed max of the XLEN/8 byte lanes of `data1`, sign-extended to XLEN.
  - 1001 FC: `acc <= acc + data1*data2` (low XLEN bits); result = new acc.
  - 1010 Conv2d: `acc <= acc + Σ signed(data1.byte[k]) * signed(data2.byte[k])`; result = new acc.
- Any other code: result 0, `illegal_o=1`, latency 1. The accumulator is unchanged.
- FSM states:
  - IDLE: `ready_o=1`. Single-cycle ops go to IDLE. MUL/FC go to MULT. Conv2d goes to DOT.
  - MULT: shift-add, one bit per cycle, XLEN cycles, then FIN.
  - DOT: one byte lane per cycle, XLEN/8 cycles, then FIN.
  - FIN: `done_o=1`, `ready_o=1`. Acts like IDLE for accepts.
- All arithmetic wraps mod 2^XLEN. There is no overflow flag.
- Accumulator:
  - `acc_clr_i` zeroes it at the clock edge.
  - If `acc_clr_i` is high in the same cycle as an FC/Conv2d accept, accumulation starts from 0.
  - `acc_clr_i` during MULT/DOT is ignored for the running op.
- Reset, including mid-op: FSM to IDLE, acc=0, in-flight op discarded, no `done_o`.

## Timing
- Reset values: `ready_o=1`, `done_o=0`, `data_o=0`, `zero_o=1`, `illegal_o=0`.
- Accept in cycle N. `done_o` is high in cycle N+L only.
- Latency L:
  - 1 for ADD/SUB/AND/OR/ReLU/MaxPool/illegal.
  - XLEN+1 for MUL/FC.
  - XLEN/8+1 for Conv2d.
- Single-cycle ops sustain one accept per cycle; `ready_o` stays 1.
- Multi-cycle ops: `ready_o=0` in cycles N+1..N+L-1 and 1 in cycle N+L. A new accept in cycle N+L is legal.
- `data_o`, `zero_o` and `illegal_o` are registered and change only together with `done_o`.

## Configuration
- `ALU_EXEC_FAST_MUL_EN` defined:
  - MUL/FC use a single-cycle combinational multiply, L=1.
  - The MULT state and the shift-add sub-module are not instantiated.
- Undefined: iterative multiply as above, L=XLEN+1.
- Conv2d stays iterative in both builds.

## Structure
- Package `alu_exec_pkg` holds:
  - the ALUCtrl code constants (shared with the ALU control decoder);
  - the FSM state encoding (IDLE, MULT, DOT, FIN);
  - the latency constants.
- Sub-module `shift_add_mul`: start/done iterative XLEN×XLEN low-half multiplier. It is used by MUL and FC and omitted when `ALU_EXEC_FAST_MUL_EN` is defined.

## Test plan
- Reset sequence, then back-to-back ADD 5+7, SUB 3-5, AND 0xF0F0&0x0FF0:
  - `data_o` 12, 0xFFFFFFFE, 0x00F0 in consecutive cycles;
  - `ready_o` held at 1.
- MUL 0x10000×0x10000:
  - `data_o=0`, `zero_o=1`, `done_o` exactly 33 cycles after accept;
  - `ready_o` low for 32 cycles;
  - with `ALU_EXEC_FAST_MUL_EN`, done after 1 cycle.
- ReLU 0x80000001 → 0. MaxPool 0x7F80FE01 → 0x0000007F. Code 0101 → 0 with `illegal_o=1`.
- `acc_clr_i` with FC 3×4, then FC 2×5:
  - results 12 then 22.
- Conv2d 0x01020304 · 0xFFFFFFFF following the FC pair:
  - result 22-10=12 at L=5.
- `rst_i` pulsed mid-MUL:
  - no `done_o`; `ready_o=1`, `data_o=0`, acc=0;
  - a subsequent FC 1×1 → 1.
